// File: rtl/es_ctrl.sv
// -----------------------------------------------------------------------------
// es_ctrl -- execution-stack command controller.
//
// Accepts one stack command per start pulse while IDLE and sequences the
// enable/opcode strobes that drive the external ES_subsys stack and its ALU.
// It keeps its own copy of the stack occupancy so commands that would
// underflow or overflow are rejected before any stack strobe is issued.
//
// Commands (cmd): 000 NOP, 001 PUSHV, 010 POP, 011 POP2, 100 ADD, 101 ADDI,
//                 110 SUB, 111 reserved (always rejected).
//
// Sequences:  NOP / rejected : IDLE -> FIN
//             PUSHV/POP/POP2 : IDLE -> ACT -> FIN
//             ADDI           : IDLE -> EXEC -> WBPUSH -> FIN
//             ADD/SUB        : IDLE -> EXEC -> WBPOP -> WBPUSH -> FIN
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous, active-high
//   start    in   command request, sampled only in IDLE
//   cmd      in   [2:0] command code, sampled with start
//   busy     out  high in every state except IDLE
//   done     out  one-cycle completion pulse (state FIN)
//   err      out  command rejected, meaningful only while done=1
//   ESAct    out  stack strobe
//   ESop     out  [1:0] 00 push, 01 pop, 10 replace top, 11 none
//   popAmt   out  0 pop one, 1 pop two
//   ALUOp    out  [1:0] 00 pass, 01 add, 10 sub
//   ALUSrcB  out  [1:0] 00 stack second entry, 01 sign-extended immediate
//   pushSel  out  push data source: 0 PushValw, 1 ALU result
//   depth    out  [DEPTHW-1:0] current stack occupancy
//
// All outputs come straight from flops: their next value is decoded from the
// next state and the next latched command, so they change only on clk edges.
// -----------------------------------------------------------------------------
module es_ctrl #(
  parameter int DEPTH  = 16,
  parameter int DEPTHW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        cmd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ESAct,
  output logic [1:0]        ESop,
  output logic              popAmt,
  output logic [1:0]        ALUOp,
  output logic [1:0]        ALUSrcB,
  output logic              pushSel,
  output logic [DEPTHW-1:0] depth
);

  // FSM state encoding
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACT    = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WBPOP  = 3'd3;
  localparam logic [2:0] S_WBPUSH = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  // Command codes
  localparam logic [2:0] C_NOP   = 3'b000;
  localparam logic [2:0] C_PUSHV = 3'b001;
  localparam logic [2:0] C_POP   = 3'b010;
  localparam logic [2:0] C_POP2  = 3'b011;
  localparam logic [2:0] C_ADD   = 3'b100;
  localparam logic [2:0] C_ADDI  = 3'b101;
  localparam logic [2:0] C_SUB   = 3'b110;

  // Stack opcodes
  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_REPL = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  // ALU controls
  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] SRCB_STK = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;

  localparam logic [DEPTHW-1:0] DEPTH_MAX = DEPTHW'(DEPTH);
  localparam logic [DEPTHW-1:0] ONE       = DEPTHW'(1);
  localparam logic [DEPTHW-1:0] TWO       = DEPTHW'(2);

  logic [2:0]        state_q,   state_d;
  logic [2:0]        cmd_q,     cmd_d;
  logic              fail_q,    fail_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;
  logic              esact_q,   esact_d;
  logic [1:0]        esop_q,    esop_d;
  logic              popamt_q,  popamt_d;
  logic [1:0]        aluop_q,   aluop_d;
  logic [1:0]        alusrcb_q, alusrcb_d;
  logic              pushsel_q, pushsel_d;
  logic [DEPTHW-1:0] depth_q,   depth_d;
  logic              cmd_ok;

  // Occupancy precondition for the command currently on cmd.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and a latch is inferred.
    cmd_ok = 1'b0;
    case (cmd)
      C_NOP:          cmd_ok = 1'b1;
      C_PUSHV:        cmd_ok = (depth_q < DEPTH_MAX);
      C_POP, C_ADDI:  cmd_ok = (depth_q >= ONE);
      C_POP2, C_ADD,
      C_SUB:          cmd_ok = (depth_q >= TWO);
      default:        cmd_ok = 1'b0;
    endcase
  end

  // Next-state logic. cmd and the pass/fail verdict are latched only on the
  // accepting edge; start outside IDLE has no effect.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d  = cmd;
          fail_d = ~cmd_ok;
          if (!cmd_ok) begin
            state_d = S_FIN;
          end else begin
            case (cmd)
              C_PUSHV, C_POP, C_POP2: state_d = S_ACT;
              C_ADD, C_SUB, C_ADDI:   state_d = S_EXEC;
              default:                state_d = S_FIN;
            endcase
          end
        end
      end
      S_ACT:    state_d = S_FIN;
      S_EXEC:   state_d = (cmd_q == C_ADDI) ? S_WBPUSH : S_WBPOP;
      S_WBPOP:  state_d = S_WBPUSH;
      S_WBPUSH: state_d = S_FIN;
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode for the state being entered, registered below.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_FIN);
    err_d     = (state_d == S_FIN) && fail_d;
    esact_d   = 1'b0;
    esop_d    = OP_NONE;
    popamt_d  = 1'b0;
    pushsel_d = 1'b0;
    aluop_d   = ALU_PASS;
    alusrcb_d = SRCB_STK;

    // The ALU setup is held from EXEC through write-back so the result it
    // produces stays stable while the stack consumes it.
    if (state_d == S_EXEC || state_d == S_WBPOP || state_d == S_WBPUSH) begin
      aluop_d   = (cmd_d == C_SUB) ? ALU_SUB : ALU_ADD;
      alusrcb_d = (cmd_d == C_ADDI) ? SRCB_IMM : SRCB_STK;
    end

    case (state_d)
      S_ACT: begin
        esact_d = 1'b1;
        case (cmd_d)
          C_PUSHV: esop_d = OP_PUSH;
          C_POP:   esop_d = OP_POP;
          C_POP2: begin
            esop_d   = OP_POP;
            popamt_d = 1'b1;
          end
          default: esop_d = OP_NONE;
        endcase
      end
      S_WBPOP: begin
        esact_d  = 1'b1;
        esop_d   = OP_POP;
        popamt_d = 1'b1;
      end
      S_WBPUSH: begin
        esact_d   = 1'b1;
        pushsel_d = 1'b1;
        // ADDI overwrites the top with top+imm instead of pop-then-push.
        esop_d    = (cmd_d == C_ADDI) ? OP_REPL : OP_PUSH;
      end
      default: ;
    endcase
  end

  // Occupancy follows the strobe being presented this cycle; saturating
  // guards keep it from wrapping even if the stack ops were ever mis-issued.
  always_comb begin
    depth_d = depth_q;
    if (esact_q) begin
      case (esop_q)
        OP_PUSH: if (depth_q != DEPTH_MAX) depth_d = depth_q + ONE;
        OP_POP: begin
          if (popamt_q) begin
            if (depth_q >= TWO) depth_d = depth_q - TWO;
          end else begin
            if (depth_q >= ONE) depth_d = depth_q - ONE;
          end
        end
        default: depth_d = depth_q;
      endcase
    end
  end

  // NOTE: reset clears every flop including the latched command, so no
  // strobe can follow a reset that lands mid-sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cmd_q     <= C_NOP;
      fail_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      esact_q   <= 1'b0;
      esop_q    <= OP_NONE;
      popamt_q  <= 1'b0;
      pushsel_q <= 1'b0;
      aluop_q   <= ALU_PASS;
      alusrcb_q <= SRCB_STK;
      depth_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      fail_q    <= fail_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      esact_q   <= esact_d;
      esop_q    <= esop_d;
      popamt_q  <= popamt_d;
      pushsel_q <= pushsel_d;
      aluop_q   <= aluop_d;
      alusrcb_q <= alusrcb_d;
      depth_q   <= depth_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign ESAct   = esact_q;
  assign ESop    = esop_q;
  assign popAmt  = popamt_q;
  assign pushSel = pushsel_q;
  assign ALUOp   = aluop_q;
  assign ALUSrcB = alusrcb_q;
  assign depth   = depth_q;

endmodule

// File: tb/tb_es_ctrl.sv
// -----------------------------------------------------------------------------
// tb_es_ctrl -- scoreboard bench for es_ctrl.
// The driver pushes the cycle-by-cycle expected outputs of each command into a
// queue; a monitor on the falling edge pops one entry for every cycle the DUT
// is busy or signalling done and compares the whole output vector.
// -----------------------------------------------------------------------------
module tb_es_ctrl;

  localparam int DEPTH  = 16;
  localparam int DEPTHW = 5;

  localparam logic [2:0] C_NOP = 3'b000, C_PUSHV = 3'b001, C_POP = 3'b010,
                         C_POP2 = 3'b011, C_ADD = 3'b100, C_ADDI = 3'b101,
                         C_SUB = 3'b110, C_RSV = 3'b111;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [2:0]        cmd;
  logic              busy, done, err, ESAct, popAmt, pushSel;
  logic [1:0]        ESop, ALUOp, ALUSrcB;
  logic [DEPTHW-1:0] depth;

  es_ctrl #(.DEPTH(DEPTH), .DEPTHW(DEPTHW)) dut (
    .clk(clk), .reset(reset), .start(start), .cmd(cmd),
    .busy(busy), .done(done), .err(err), .ESAct(ESAct), .ESop(ESop),
    .popAmt(popAmt), .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .pushSel(pushSel),
    .depth(depth)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              busy, done, err, esact;
    logic [1:0]        esop;
    logic              popamt, pushsel;
    logic [1:0]        aluop, srcb;
    logic [DEPTHW-1:0] depth;
  } outs_t;

  typedef struct {
    int    cyc;
    outs_t o;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_depth = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic outs_t mk(logic b, logic dn, logic e, logic act, logic [1:0] op,
                               logic pa, logic ps, logic [1:0] alu, logic [1:0] sb, int d);
    outs_t o;
    o = '{b, dn, e, act, op, pa, ps, alu, sb, DEPTHW'(d)};
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    o = '{busy, done, err, ESAct, ESop, popAmt, pushSel, ALUOp, ALUSrcB, depth};
    return o;
  endfunction

  task automatic put(input int c, input outs_t o);
    exp_t e;
    e.cyc = c;
    e.o   = o;
    q.push_back(e);
  endtask

  // Hand-written expected sequence for command c accepted so that its first
  // post-accept cycle is acc. Updates the bench's occupancy model.
  task automatic push_seq(input logic [2:0] c, input int acc, output int lat);
    int d;
    bit ok;
    d = exp_depth;
    case (c)
      C_NOP:          ok = 1;
      C_PUSHV:        ok = (d < DEPTH);
      C_POP, C_ADDI:  ok = (d >= 1);
      C_POP2, C_ADD,
      C_SUB:          ok = (d >= 2);
      default:        ok = 0;
    endcase
    if (!ok || c == C_NOP) begin
      put(acc, mk(1, 1, !ok, 0, 2'b11, 0, 0, 2'b00, 2'b00, d));
      lat = 1;
    end else begin
      case (c)
        C_PUSHV, C_POP, C_POP2: begin
          put(acc,     mk(1, 0, 0, 1, (c == C_PUSHV) ? 2'b00 : 2'b01, c == C_POP2, 0,
                          2'b00, 2'b00, d));
          exp_depth = (c == C_PUSHV) ? d + 1 : (c == C_POP) ? d - 1 : d - 2;
          put(acc + 1, mk(1, 1, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, exp_depth));
          lat = 2;
        end
        C_ADDI: begin
          put(acc,     mk(1, 0, 0, 0, 2'b11, 0, 0, 2'b01, 2'b01, d));
          put(acc + 1, mk(1, 0, 0, 1, 2'b10, 0, 1, 2'b01, 2'b01, d));
          put(acc + 2, mk(1, 1, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, d));
          lat = 3;
        end
        default: begin  // ADD / SUB
          logic [1:0] a;
          a = (c == C_SUB) ? 2'b10 : 2'b01;
          put(acc,     mk(1, 0, 0, 0, 2'b11, 0, 0, a, 2'b00, d));
          put(acc + 1, mk(1, 0, 0, 1, 2'b01, 1, 0, a, 2'b00, d));
          put(acc + 2, mk(1, 0, 0, 1, 2'b00, 0, 1, a, 2'b00, d - 2));
          put(acc + 3, mk(1, 1, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, d - 1));
          exp_depth = d - 1;
          lat = 4;
        end
      endcase
    end
  endtask

  // Monitor: one queue entry per busy/done cycle; idle cycles must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (busy || done) begin
      if (q.size() == 0) begin
        check("unexpected_output", {30'd0, busy, done}, 32'd0);
      end else begin
        e = q.pop_front();
        check("out_cycle", cyc, e.cyc);
        check("outs", 32'(dut_outs()), 32'(e.o));
      end
    end else begin
      check("idle_quiet", {22'd0, ESAct, ESop, popAmt, pushSel, ALUOp, ALUSrcB, err},
            {22'd0, 10'b0110000000});
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy && !done) return;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (q.size() == 0) return;
      @(negedge clk);
    end
    check("drain_timeout", q.size(), 32'd0);
  endtask

  task automatic issue(input logic [2:0] c);
    int acc, lat;
    wait_idle();
    start = 1'b1;
    cmd   = c;
    acc   = cyc + 1;
    push_seq(c, acc, lat);
    @(posedge clk);
    #1 start = 1'b0;
    drain();
  endtask

  initial begin
    int acc, lat, lat2;
    reset = 1'b1;
    start = 1'b0;
    cmd   = C_NOP;
    #1;
    check("reset_outs", 32'(dut_outs()), 32'(mk(0, 0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0)));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Underflow rejections at depth 0.
    issue(C_POP);
    issue(C_ADD);
    // Two pushes then ADD: push, push, pop2, push.
    issue(C_PUSHV);
    issue(C_PUSHV);
    issue(C_ADD);
    // ADDI at depth 1 replaces the top.
    issue(C_ADDI);
    issue(C_NOP);
    issue(C_RSV);
    issue(C_PUSHV);

    // start held through SUB; cmd changed mid-sequence must be ignored until
    // the following IDLE, where POP is accepted.
    wait_idle();
    start = 1'b1;
    cmd   = C_SUB;
    acc   = cyc + 1;
    push_seq(C_SUB, acc, lat);
    push_seq(C_POP, acc + lat + 1, lat2);
    @(posedge clk);
    #1 cmd = C_POP;
    repeat (lat) @(posedge clk);
    @(posedge clk);
    #1 start = 1'b0;
    drain();
    check("depth_after_hold", {27'd0, depth}, 32'd0);

    // Fill to DEPTH, overflow rejection, then POP2.
    for (int i = 0; i < DEPTH; i++) issue(C_PUSHV);
    check("depth_full", {27'd0, depth}, 32'(DEPTH));
    issue(C_PUSHV);
    issue(C_POP2);
    check("depth_after_pop2", {27'd0, depth}, 32'(DEPTH - 2));

    // Reset during WBPOP of ADD.
    wait_idle();
    start = 1'b1;
    cmd   = C_ADD;
    acc   = cyc + 1;
    put(acc, mk(1, 0, 0, 0, 2'b11, 0, 0, 2'b01, 2'b00, exp_depth));
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_depth = 0;
    #1;
    check("reset_midseq", 32'(dut_outs()), 32'(mk(0, 0, 0, 0, 2'b11, 0, 0, 2'b00, 2'b00, 0)));
    start = 1'b1;
    cmd   = C_PUSHV;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("depth_post_reset", {27'd0, depth}, 32'd0);
    issue(C_RSV);
    issue(C_ADDI);
    issue(C_PUSHV);
    check("depth_final", {27'd0, depth}, 32'd1);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
